// File: rtl/dispatch_ctrl_pkg.sv
// Shared dispatch-stage definitions: core widths, FSM state encoding and the
// freelist availability decode used by the dispatch controller.
package dispatch_ctrl_pkg;

    localparam int         SCALAR_WIDTH           = 2;
    localparam int         PREG_IDX_WIDTH         = 6;
    localparam logic [4:0] ZERO_REG               = 5'd0;
    localparam int         RECOVER_CYCLES_DEFAULT = 2;
    localparam int         RECOVER_CNT_WIDTH      = 4;

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        RUN     = 2'd1,
        RECOVER = 2'd2
    } dispatch_state_t;

    // Freelist reports availability as a thermometer; 2'b10 is not a legal code.
    function automatic logic [1:0] fl_avail_decode(input logic [1:0] fl_valid);
        case (fl_valid)
            2'b01:   return 2'd1;
            2'b11:   return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dispatch_grant.sv
// Two-slot in-order grant logic: slot 1 may only go when slot 0 goes and the
// combined freelist, ROB and RS demand of both slots is covered.
module dispatch_grant
    import dispatch_ctrl_pkg::*;
#(
    parameter int ROB_CNT_WIDTH = 6
) (
    input  logic [1:0]               dec_valid,
    input  logic [1:0]               need,
    input  logic [1:0]               fl_avail,
    input  logic [ROB_CNT_WIDTH-1:0] rob_free,
    input  logic [ROB_CNT_WIDTH-1:0] rs_free,
    output logic [1:0]               grant
);

    logic [1:0] need_total;

    always_comb begin
        need_total = {1'b0, need[0]} + {1'b0, need[1]};
        grant[0]   = dec_valid[0]
                  && (rob_free != '0)
                  && (rs_free != '0)
                  && (fl_avail >= {1'b0, need[0]});
        grant[1]   = grant[0]
                  && dec_valid[1]
                  && (rob_free >= ROB_CNT_WIDTH'(2))
                  && (rs_free >= ROB_CNT_WIDTH'(2))
                  && (fl_avail >= need_total);
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch-stage controller: per-slot grants for the 2-way core, plus the
// mispredict-recovery sequencer that pulses the freelist rollback and blocks dispatch.
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int SCALAR_WIDTH   = dispatch_ctrl_pkg::SCALAR_WIDTH,
    parameter int RECOVER_CYCLES = RECOVER_CYCLES_DEFAULT,
    parameter int ROB_CNT_WIDTH  = 6
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [SCALAR_WIDTH-1:0]           dec_valid,
    input  logic [SCALAR_WIDTH-1:0][4:0]      dec_dest_idx,
    input  logic [SCALAR_WIDTH-1:0]           fl_valid,
    input  logic [ROB_CNT_WIDTH-1:0]          rob_free,
    input  logic [ROB_CNT_WIDTH-1:0]          rs_free,
    input  logic                              rollback_req,
    output logic [SCALAR_WIDTH-1:0]           dispatch_en,
    output logic [1:0]                        buf_consume,
    output logic                              fl_rollback_en,
    output logic                              dispatch_stall,
    output logic [15:0]                       stall_cycles,
    output dispatch_state_t                   dbg_state,
    output logic [RECOVER_CNT_WIDTH-1:0]      dbg_recover_cnt
);

    dispatch_state_t              state;
    logic [RECOVER_CNT_WIDTH-1:0] recover_cnt;
    logic [1:0]                   need;
    logic [1:0]                   fl_avail;
    logic [1:0]                   grant;
    logic                         run_ok;

    always_comb begin
        need[0]  = dec_valid[0] && (dec_dest_idx[0] != ZERO_REG);
        need[1]  = dec_valid[1] && (dec_dest_idx[1] != ZERO_REG);
        fl_avail = fl_avail_decode(fl_valid);
    end

    dispatch_grant #(
        .ROB_CNT_WIDTH (ROB_CNT_WIDTH)
    ) u_grant (
        .dec_valid (dec_valid),
        .need      (need),
        .fl_avail  (fl_avail),
        .rob_free  (rob_free),
        .rs_free   (rs_free),
        .grant     (grant)
    );

    // dec_valid[i] offers slot i; dispatch_en[i] accepts it in the same cycle
    // (no backpressure beyond the grant). A rollback request suppresses all grants at once.
    always_comb begin
        run_ok         = (state == RUN) && !rollback_req;
        dispatch_en    = run_ok ? grant : 2'b00;
        buf_consume    = {dispatch_en[1] & dispatch_en[0], dispatch_en[1] ^ dispatch_en[0]};
        dispatch_stall = run_ok && dec_valid[0] && !grant[0];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= INIT;
            recover_cnt    <= '0;
            fl_rollback_en <= 1'b0;
            stall_cycles   <= '0;
        end else begin
            fl_rollback_en <= rollback_req;
            if (dispatch_stall && (stall_cycles != 16'hFFFF))
                stall_cycles <= stall_cycles + 16'd1;
            if (rollback_req) begin
                state       <= RECOVER;
                recover_cnt <= RECOVER_CNT_WIDTH'(RECOVER_CYCLES);
            end else begin
                case (state)
                    INIT:    state <= RUN;
                    RUN:     state <= RUN;
                    RECOVER: begin
                        if (recover_cnt <= RECOVER_CNT_WIDTH'(1)) begin
                            state       <= RUN;
                            recover_cnt <= '0;
                        end else begin
                            recover_cnt <= recover_cnt - RECOVER_CNT_WIDTH'(1);
                        end
                    end
                    default: state <= INIT;
                endcase
            end
        end
    end

    assign dbg_state       = state;
    assign dbg_recover_cnt = recover_cnt;

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Bench for dispatch_ctrl: directed cases, randomized traffic, rollback timing,
// reset during recovery and stall-counter saturation against a cycle model.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    localparam int RC = 2;
    localparam int CW = 6;
    localparam int W  = 28;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [1:0]            dec_valid;
    logic [1:0][4:0]       dec_dest_idx;
    logic [1:0]            fl_valid;
    logic [CW-1:0]         rob_free;
    logic [CW-1:0]         rs_free;
    logic                  rollback_req;
    logic [1:0]            dispatch_en;
    logic [1:0]            buf_consume;
    logic                  fl_rollback_en;
    logic                  dispatch_stall;
    logic [15:0]           stall_cycles;
    dispatch_state_t       dbg_state;
    logic [3:0]            dbg_recover_cnt;

    always #5 clock = ~clock;

    dispatch_ctrl #(
        .SCALAR_WIDTH   (2),
        .RECOVER_CYCLES (RC),
        .ROB_CNT_WIDTH  (CW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .dec_valid       (dec_valid),
        .dec_dest_idx    (dec_dest_idx),
        .fl_valid        (fl_valid),
        .rob_free        (rob_free),
        .rs_free         (rs_free),
        .rollback_req    (rollback_req),
        .dispatch_en     (dispatch_en),
        .buf_consume     (buf_consume),
        .fl_rollback_en  (fl_rollback_en),
        .dispatch_stall  (dispatch_stall),
        .stall_cycles    (stall_cycles),
        .dbg_state       (dbg_state),
        .dbg_recover_cnt (dbg_recover_cnt)
    );

    logic [W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    bit m_init;
    int m_block;
    bit m_pulse;
    int m_stall_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input logic rst, input logic [1:0] dv, input logic [4:0] d0,
                        input logic [4:0] d1, input logic [1:0] fv, input logic [CW-1:0] rob,
                        input logic [CW-1:0] rs, input logic req);
        logic [1:0]   g;
        logic [1:0]   cons;
        logic [1:0]   st;
        logic [W-1:0] e;
        logic [W-1:0] a;
        int           fa, n0, n1;
        bit           run, stall;
        @(negedge clock);
        reset           = rst;
        dec_valid       = dv;
        dec_dest_idx[0] = d0;
        dec_dest_idx[1] = d1;
        fl_valid        = fv;
        rob_free        = rob;
        rs_free         = rs;
        rollback_req    = req;

        fa  = (fv == 2'b11) ? 2 : (fv == 2'b01) ? 1 : 0;
        n0  = (dv[0] && d0 != 5'd0) ? 1 : 0;
        n1  = (dv[1] && d1 != 5'd0) ? 1 : 0;
        run = !m_init && (m_block == 0);
        g   = 2'b00;
        if (run && !req) begin
            g[0] = dv[0] && (rob >= 1) && (rs >= 1) && (fa >= n0);
            g[1] = g[0] && dv[1] && (rob >= 2) && (rs >= 2) && (fa >= n0 + n1);
        end
        stall = run && !req && dv[0] && !g[0];
        cons  = 2'(int'(g[0]) + int'(g[1]));
        st    = m_init ? 2'd0 : ((m_block > 0) ? 2'd2 : 2'd1);
        exp_q.push_back({g, cons, stall, m_pulse, 16'(m_stall_cnt), 4'(m_block), st});

        #1;
        a = {dispatch_en, buf_consume, dispatch_stall, fl_rollback_en, stall_cycles,
             dbg_recover_cnt, dbg_state};
        e = exp_q.pop_front();
        check("dispatch_en",    32'(a[27:26]), 32'(e[27:26]));
        check("buf_consume",    32'(a[25:24]), 32'(e[25:24]));
        check("dispatch_stall", 32'(a[23]),    32'(e[23]));
        check("fl_rollback_en", 32'(a[22]),    32'(e[22]));
        check("stall_cycles",   32'(a[21:6]),  32'(e[21:6]));
        check("recover_cnt",    32'(a[5:2]),   32'(e[5:2]));
        check("state",          32'(a[1:0]),   32'(e[1:0]));

        if (rst) begin
            m_init      = 1;
            m_block     = 0;
            m_pulse     = 0;
            m_stall_cnt = 0;
        end else begin
            if (stall && m_stall_cnt < 65535) m_stall_cnt++;
            m_pulse = req;
            if (req) m_block = RC;
            else if (m_block > 0) m_block--;
            m_init = 0;
        end
    endtask

    logic [1:0] fv_tab [3] = '{2'b00, 2'b01, 2'b11};

    initial begin
        reset        = 1'b1;
        dec_valid    = 2'b00;
        dec_dest_idx = '0;
        fl_valid     = 2'b11;
        rob_free     = 6'd8;
        rs_free      = 6'd8;
        rollback_req = 1'b0;
        repeat (2) @(posedge clock);
        m_init = 1; m_block = 0; m_pulse = 0; m_stall_cnt = 0;

        // reset release: INIT cycle blocks, then dual dispatch
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        // freelist shortage
        step(0, 2'b11, 5'd3, 5'd4, 2'b01, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd0, 2'b01, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b00, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd0, 5'd0, 2'b00, 6'd8, 6'd8, 0);
        // resource limits
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd1, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd0, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd0, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd1, 0);
        step(0, 2'b10, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        // single rollback then resume
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 1);
        repeat (5) step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        // back-to-back rollback
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 1);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 1);
        repeat (5) step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);

        for (int i = 0; i < 400; i++) begin
            step(0, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 fv_tab[$urandom_range(0, 2)], 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) == 0));
        end

        // reset in the same cycle as a request, then reset mid-recovery
        step(1, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 1);
        repeat (3) step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 1);
        step(1, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        repeat (3) step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);

        // stall-counter saturation
        repeat (70000) step(0, 2'b01, 5'd5, 5'd0, 2'b11, 6'd8, 6'd0, 0);
        check("stall_sat", 32'(stall_cycles), 32'hFFFF);
        step(0, 2'b01, 5'd5, 5'd0, 2'b11, 6'd8, 6'd8, 1);
        step(1, 2'b01, 5'd5, 5'd0, 2'b11, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);
        step(0, 2'b11, 5'd3, 5'd4, 2'b11, 6'd8, 6'd8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
